// File: rtl/demux_1x8_stream_pkg.sv
// Shared lane-count, select-width and pointer constants for the 1-to-8 stream demux,
// plus small helpers for pointer advance and one-hot lane decode.
package demux_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t PTR_LAST = 3'd7;

  // Pointer width matches the lane count exactly, so natural overflow gives the 7->0 wrap.
  function automatic sel_t ptr_next(input sel_t p);
    return p + sel_t'(1);
  endfunction

  function automatic logic [LANES-1:0] lane_onehot(input sel_t s);
    logic [LANES-1:0] one;
    one = {{(LANES-1){1'b0}}, 1'b1};
    return one << s;
  endfunction

endpackage

// File: rtl/demux_1x8_stream_if.sv
// Stream-side bundle for the 1-to-8 demux: one input channel with select/mode,
// eight output lanes with per-lane valid/ready, and frame/pointer status.
interface demux_1x8_stream_if #(
  parameter int WIDTH = 4
);
  import demux_pkg::*;

  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  sel_t                   in_sel;
  logic                   auto_mode;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       out_valid;
  logic [LANES-1:0]       out_ready;
  logic                   frame_done;
  sel_t                   ptr;

  modport master (
    output in_data, in_valid, in_sel, auto_mode, out_ready,
    input  in_ready, out_data, out_valid, frame_done, ptr
  );

  modport slave (
    input  in_data, in_valid, in_sel, auto_mode, out_ready,
    output in_ready, out_data, out_valid, frame_done, ptr
  );

endinterface

// File: rtl/demux_1x8_stream_lane.sv
// One-entry output slice: load wins over consume; 1-cycle latency, and space is
// asserted when empty or draining this cycle, so a full lane still streams at full rate.
module demux_lane #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             consume,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             space
);

  assign space = !valid || consume;

  // Data is kept on consume; consumers qualify it with valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= din;
      valid <= 1'b1;
    end else if (valid && consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1x8_stream.sv
// Registered 1-to-8 stream demux, explicit or round-robin lane select; 1-cycle latency.
// in_ready follows the targeted lane's space combinationally; a stalled word changes nothing.
module demux_1x8_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  demux_1x8_stream_if.slave bus
);

  sel_t                        ptr_q;
  sel_t                        tgt;
  logic                        in_ready;
  logic                        acc;
  logic                        frame_q;
  logic [LANES-1:0]            space;
  logic [LANES-1:0]            load;
  logic [LANES-1:0]            lane_valid;
  logic [LANES-1:0][WIDTH-1:0] lane_data;

  // Mode toggles steer the same cycle; only the pointer reset waits for the edge.
  assign tgt      = bus.auto_mode ? ptr_q : bus.in_sel;
  assign in_ready = space[tgt];
  assign acc      = bus.in_valid && in_ready;
  assign load     = acc ? lane_onehot(tgt) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (!bus.auto_mode) begin
      ptr_q <= '0;
    end else if (acc) begin
      ptr_q <= ptr_next(ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= 1'b0;
    end else begin
      frame_q <= acc && bus.auto_mode && (ptr_q == PTR_LAST);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    demux_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load    (load[k]),
      .din     (bus.in_data),
      .consume (bus.out_ready[k]),
      .data    (lane_data[k]),
      .valid   (lane_valid[k]),
      .space   (space[k])
    );
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_data   = lane_data;
  assign bus.out_valid  = lane_valid;
  assign bus.frame_done = frame_q;
  assign bus.ptr        = ptr_q;

endmodule

// File: tb/tb_demux_1x8_stream.sv
// Directed bench for demux_1x8_stream: explicit and round-robin steering, per-lane
// backpressure, mode switching and mid-frame reset, with hand-computed expectations.
module tb_demux_1x8_stream;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  demux_1x8_stream_if #(.WIDTH(4)) bus ();

  demux_1x8_stream #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] lane_of(input logic [31:0] v, input int k);
    return v[k*4 +: 4];
  endfunction

  task automatic idle_inputs;
    bus.in_data   = 4'h0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 3'd0;
    bus.auto_mode = 1'b0;
    bus.out_ready = 8'hFF;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 8'h00) begin
      failures++; $display("FAIL reset_out_valid got=%h exp=00", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 32'h0) begin
      failures++; $display("FAIL reset_out_data got=%h exp=00000000", bus.out_data);
    end
    checks++;
    if (bus.ptr !== 3'd0) begin
      failures++; $display("FAIL reset_ptr got=%0d exp=0", bus.ptr);
    end
    checks++;
    if (bus.frame_done !== 1'b0) begin
      failures++; $display("FAIL reset_frame_done got=%b exp=0", bus.frame_done);
    end
    bus.out_ready = 8'h00;
    for (int s = 0; s < 8; s++) begin
      bus.in_sel = 3'(s);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++; $display("FAIL reset_in_ready sel=%0d got=%b exp=1", s, bus.in_ready);
      end
    end
    bus.out_ready = 8'hFF;
    tick();
  endtask

  task automatic test_explicit;
    bus.auto_mode = 1'b0;
    bus.out_ready = 8'hFF;
    bus.in_sel    = 3'd5;
    bus.in_data   = 4'hA;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    checks++;
    if (bus.out_valid !== 8'b0010_0000) begin
      failures++; $display("FAIL explicit_valid got=%b exp=00100000", bus.out_valid);
    end
    checks++;
    if (lane_of(bus.out_data, 5) !== 4'hA) begin
      failures++; $display("FAIL explicit_lane5 got=%h exp=a", lane_of(bus.out_data, 5));
    end
    tick();
    checks++;
    if (bus.out_valid !== 8'h00) begin
      failures++; $display("FAIL explicit_drain got=%b exp=00000000", bus.out_valid);
    end
    checks++;
    if (lane_of(bus.out_data, 5) !== 4'hA) begin
      failures++; $display("FAIL explicit_hold got=%h exp=a", lane_of(bus.out_data, 5));
    end
  endtask

  task automatic test_auto_frame;
    bus.auto_mode = 1'b1;
    bus.out_ready = 8'hFF;
    bus.in_sel    = 3'd3;
    for (int i = 0; i < 8; i++) begin
      bus.in_data  = 4'(i + 1);
      bus.in_valid = 1'b1;
      #1;
      checks++;
      if (bus.ptr !== 3'(i)) begin
        failures++; $display("FAIL auto_ptr word=%0d got=%0d exp=%0d", i + 1, bus.ptr, i);
      end
      tick();
      checks++;
      if (bus.frame_done !== (i == 7)) begin
        failures++; $display("FAIL auto_frame_done word=%0d got=%b exp=%b", i + 1, bus.frame_done, i == 7);
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_data !== 32'h8765_4321) begin
      failures++; $display("FAIL auto_lanes got=%h exp=87654321", bus.out_data);
    end
    checks++;
    if (bus.out_valid !== 8'h80) begin
      failures++; $display("FAIL auto_last_valid got=%b exp=10000000", bus.out_valid);
    end
    checks++;
    if (bus.ptr !== 3'd0) begin
      failures++; $display("FAIL auto_wrap got=%0d exp=0", bus.ptr);
    end
    tick();
    checks++;
    if (bus.frame_done !== 1'b0) begin
      failures++; $display("FAIL auto_frame_pulse_width got=%b exp=0", bus.frame_done);
    end
    checks++;
    if (bus.out_valid !== 8'h00) begin
      failures++; $display("FAIL auto_drain got=%b exp=00000000", bus.out_valid);
    end
  endtask

  task automatic test_backpressure;
    bus.auto_mode = 1'b0;
    bus.out_ready = 8'h00;
    bus.in_sel    = 3'd2;
    bus.in_data   = 4'h3;
    bus.in_valid  = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 8'h04 || lane_of(bus.out_data, 2) !== 4'h3) begin
      failures++; $display("FAIL bp_first valid=%b lane2=%h exp valid=00000100 lane2=3", bus.out_valid, lane_of(bus.out_data, 2));
    end
    bus.in_data = 4'h4;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_stall_ready got=%b exp=0", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 8'h04 || lane_of(bus.out_data, 2) !== 4'h3) begin
      failures++; $display("FAIL bp_stall_hold valid=%b lane2=%h exp valid=00000100 lane2=3", bus.out_valid, lane_of(bus.out_data, 2));
    end
    // lane 6 is independent of the stalled lane 2
    bus.in_sel  = 3'd6;
    bus.in_data = 4'h9;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_other_ready got=%b exp=1", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 8'h44 || lane_of(bus.out_data, 6) !== 4'h9 || lane_of(bus.out_data, 2) !== 4'h3) begin
      failures++; $display("FAIL bp_other_lane valid=%b data=%h exp valid=01000100 lane6=9 lane2=3", bus.out_valid, bus.out_data);
    end
    bus.in_sel    = 3'd2;
    bus.in_data   = 4'h4;
    bus.out_ready = 8'h04;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 8'h44 || lane_of(bus.out_data, 2) !== 4'h4) begin
      failures++; $display("FAIL bp_replace valid=%b lane2=%h exp valid=01000100 lane2=4", bus.out_valid, lane_of(bus.out_data, 2));
    end
    bus.out_ready = 8'hFF;
    tick();
    checks++;
    if (bus.out_valid !== 8'h00) begin
      failures++; $display("FAIL bp_drain got=%b exp=00000000", bus.out_valid);
    end
  endtask

  task automatic test_mode_switch;
    bus.auto_mode = 1'b1;
    bus.out_ready = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      bus.in_data  = 4'(4'hC + i);
      bus.in_valid = 1'b1;
      tick();
    end
    checks++;
    if (bus.ptr !== 3'd3) begin
      failures++; $display("FAIL mode_ptr_advance got=%0d exp=3", bus.ptr);
    end
    bus.auto_mode = 1'b0;
    bus.in_sel    = 3'd1;
    bus.in_data   = 4'hB;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.ptr !== 3'd0) begin
      failures++; $display("FAIL mode_ptr_cleared got=%0d exp=0", bus.ptr);
    end
    checks++;
    if (bus.out_valid !== 8'h02 || lane_of(bus.out_data, 1) !== 4'hB) begin
      failures++; $display("FAIL mode_follows_sel valid=%b lane1=%h exp valid=00000010 lane1=b", bus.out_valid, lane_of(bus.out_data, 1));
    end
    tick();
  endtask

  task automatic test_reset_mid_frame;
    bus.auto_mode = 1'b1;
    bus.out_ready = 8'h00;
    for (int i = 0; i < 5; i++) begin
      bus.in_data  = 4'(i + 1);
      bus.in_valid = 1'b1;
      tick();
    end
    checks++;
    if (bus.out_valid !== 8'h1F || bus.ptr !== 3'd5) begin
      failures++; $display("FAIL midrst_prefill valid=%b ptr=%0d exp valid=00011111 ptr=5", bus.out_valid, bus.ptr);
    end
    // reset outranks a pending accept and drains in the same edge
    bus.out_ready = 8'hFF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 8'h00 || bus.out_data !== 32'h0) begin
      failures++; $display("FAIL midrst_lanes valid=%b data=%h exp valid=00000000 data=00000000", bus.out_valid, bus.out_data);
    end
    checks++;
    if (bus.ptr !== 3'd0 || bus.frame_done !== 1'b0) begin
      failures++; $display("FAIL midrst_ptr_fd ptr=%0d fd=%b exp ptr=0 fd=0", bus.ptr, bus.frame_done);
    end
    tick();
    checks++;
    if (bus.frame_done !== 1'b0 || bus.out_valid !== 8'h00) begin
      failures++; $display("FAIL midrst_after fd=%b valid=%b exp fd=0 valid=00000000", bus.frame_done, bus.out_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_explicit();
    test_auto_frame();
    test_backpressure();
    test_mode_switch();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
